// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_pkg
// Description : Shared encodings for the EX-stage multiply/divide sequencer:
//               operation codes, FSM state codes and word-bus helpers.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef WORD_BUS
`define WORD_BUS 31:0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

package muldiv_ctrl_pkg;

  localparam int MDU_WORD_W = 32;

  // Operation select driven by the decoder (bit 1 = divide, bit 0 = unsigned)
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : Pipeline <-> multiply/divide sequencer bundle. The master side
//               (pipeline) issues operations and flushes; the slave side
//               (sequencer) returns stall and the HI/LO write port.
// Revision    : 1.0 - initial release
// ============================================================================

interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_stall;
  logic             o_we;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_stall, o_we, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_stall, o_we, o_hi, o_lo
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_ctrl_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               {rem,quot} pair left by one and subtracts the divisor when the
//               shifted remainder is large enough, recording a quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================

module muldiv_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic [WIDTH-1:0] i_quot,
  input  wire logic [WIDTH-1:0] i_divisor,
  output logic      [WIDTH-1:0] o_rem,
  output logic      [WIDTH-1:0] o_quot
);

  // One extra bit: the shifted remainder can reach 2*divisor-1, and the
  // difference's top bit then doubles as the "rem < divisor" flag.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Trial subtraction, restore (keep the shifted value) when it goes negative
  always_comb begin
    w_shift = {i_rem, i_quot[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_divisor};
    if (!w_diff[WIDTH]) begin
      o_rem  = w_diff[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b1};
    end else begin
      o_rem  = w_shift[WIDTH-1:0];
      o_quot = {i_quot[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : EX-stage multiply/divide sequencer. MULT/MULTU finish in one
//               cycle, DIV/DIVU run a restoring divider for DIV_ITERS cycles
//               followed by a sign-fixup write cycle. Drives the HI/LO write
//               port and the pipeline stall request.
// Revision    : 1.0 - initial release
// ============================================================================

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32   // must equal WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               w_is_div;
  logic               w_signed;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_step_quot;

  muldiv_ctrl_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (rem_q),
    .i_quot    (quot_q),
    .i_divisor (dvsr_q),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  // Operand conditioning: one multiplier serves both signednesses by
  // sign- or zero-extending to the full product width first.
  always_comb begin
    w_is_div = (bus.i_op == MDU_DIV) || (bus.i_op == MDU_DIVU);
    w_signed = (bus.i_op == MDU_MULT) || (bus.i_op == MDU_DIV);
    w_a_ext  = {{WIDTH{w_signed & bus.i_a[WIDTH-1]}}, bus.i_a};
    w_b_ext  = {{WIDTH{w_signed & bus.i_b[WIDTH-1]}}, bus.i_b};
    w_prod   = w_a_ext * w_b_ext;
    w_abs_a  = (w_signed && bus.i_a[WIDTH-1]) ? -bus.i_a : bus.i_a;
    w_abs_b  = (w_signed && bus.i_b[WIDTH-1]) ? -bus.i_b : bus.i_b;
  end

  // Next-state and datapath updates; a flush abandons everything untouched
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            if (!w_is_div) begin
              hi_d    = w_prod[2*WIDTH-1:WIDTH];
              lo_d    = w_prod[WIDTH-1:0];
              state_d = ST_MUL;
            end else if (bus.i_b == '0) begin
              hi_d    = bus.i_a;
              lo_d    = '1;
              state_d = ST_DONE;
            end else begin
              rem_d   = '0;
              quot_d  = w_abs_a;
              dvsr_d  = w_abs_b;
              qneg_d  = w_signed & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
              rneg_d  = w_signed & bus.i_a[WIDTH-1];
              cnt_d   = '0;
              state_d = ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem_d  = w_step_rem;
          quot_d = w_step_quot;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
            // Sign fixup is folded into the result load so FIX only writes
            hi_d    = rneg_q ? -w_step_rem  : w_step_rem;
            lo_d    = qneg_q ? -w_step_quot : w_step_quot;
            state_d = ST_FIX;
          end
        end
        ST_MUL, ST_FIX, ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall covers acceptance and iteration; write cycles let the pipe advance
  always_comb begin
    bus.o_stall = !bus.i_flush &&
                  (((state_q == ST_IDLE) && bus.i_start) || (state_q == ST_DIV));
    bus.o_we    = !bus.i_flush &&
                  ((state_q == ST_MUL) || (state_q == ST_FIX) || (state_q == ST_DONE));
    bus.o_hi    = hi_q;
    bus.o_lo    = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for the multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(
    .WIDTH     (32),
    .DIV_ITERS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic f);
    bus.i_start = s;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_flush = f;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick; tick; #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0)
      $display("FAIL reset_outputs: we=%b stall=%b hi=%h lo=%h, want 0 0 0 0",
               bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo);
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) errs++;
    // Stall follows i_start in IDLE even while reset holds
    drive(1'b1, 2'b00, 32'h3, 32'h3, 1'b0);
    #1;
    vecs++;
    if (bus.o_stall !== 1'b1) begin
      errs++; $display("FAIL reset_stall_start: stall=%b want 1", bus.o_stall);
    end
    tick;
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_lo !== 32'h0) begin
      errs++; $display("FAIL reset_beats_start: we=%b lo=%h want 0 0", bus.o_we, bus.o_lo);
    end
    last_hi = 32'h0;
    last_lo = 32'h0;
  endtask

  task automatic test_mult;
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] as  [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
    logic [31:0] bs  [4] = '{32'h00000003, 32'hFFFFFFFF, 32'h80000000, 32'h00010000};
    logic [31:0] ehs [4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'h00000001};
    logic [31:0] els [4] = '{32'hFFFFFFFA, 32'h00000001, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      tick;
      drive(1'b1, ops[i], as[i], bs[i], 1'b0);
      #2;
      vecs++;
      if (bus.o_stall !== 1'b1 || bus.o_we !== 1'b0) begin
        errs++; $display("FAIL mult%0d_c0: stall=%b we=%b want 1 0", i, bus.o_stall, bus.o_we);
      end
      tick;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #2;
      vecs++;
      if (bus.o_we !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_hi !== ehs[i] || bus.o_lo !== els[i]) begin
        errs++;
        $display("FAIL mult%0d_c1: we=%b stall=%b hi=%h lo=%h want 1 0 %h %h",
                 i, bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo, ehs[i], els[i]);
      end
      tick; #2;
      vecs++;
      if (bus.o_we !== 1'b0 || bus.o_hi !== ehs[i] || bus.o_lo !== els[i]) begin
        errs++;
        $display("FAIL mult%0d_hold: we=%b hi=%h lo=%h want 0 %h %h",
                 i, bus.o_we, bus.o_hi, bus.o_lo, ehs[i], els[i]);
      end
      last_hi = ehs[i];
      last_lo = els[i];
    end
  endtask

  task automatic test_div;
    logic [1:0]  ops [5] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00000007, 32'd100};
    logic [31:0] bs  [5] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7};
    logic [31:0] ehs [5] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'd2};
    logic [31:0] els [5] = '{32'h7FFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'd14};
    int bad;
    for (int i = 0; i < 5; i++) begin
      tick;
      drive(1'b1, ops[i], as[i], bs[i], 1'b0);
      #2;
      vecs++;
      if (bus.o_stall !== 1'b1 || bus.o_we !== 1'b0) begin
        errs++; $display("FAIL div%0d_c0: stall=%b we=%b want 1 0", i, bus.o_stall, bus.o_we);
      end
      bad = 0;
      for (int c = 1; c <= 32; c++) begin
        tick; #2;
        vecs++;
        if (bus.o_stall !== 1'b1 || bus.o_we !== 1'b0) begin
          errs++;
          if (bad == 0)
            $display("FAIL div%0d_busy: cycle %0d stall=%b we=%b want 1 0", i, c, bus.o_stall, bus.o_we);
          bad++;
        end
      end
      tick; #2;
      vecs++;
      if (bus.o_we !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_hi !== ehs[i] || bus.o_lo !== els[i]) begin
        errs++;
        $display("FAIL div%0d_c33: we=%b stall=%b hi=%h lo=%h want 1 0 %h %h",
                 i, bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo, ehs[i], els[i]);
      end
      tick;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #2;
      vecs++;
      if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_hi !== ehs[i] || bus.o_lo !== els[i]) begin
        errs++;
        $display("FAIL div%0d_after: we=%b stall=%b hi=%h lo=%h want 0 0 %h %h",
                 i, bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo, ehs[i], els[i]);
      end
      last_hi = ehs[i];
      last_lo = els[i];
    end
  endtask

  task automatic test_div_zero;
    logic [1:0]  ops [2] = '{2'b10, 2'b11};
    logic [31:0] as  [2] = '{32'd5, 32'h0000ABCD};
    for (int i = 0; i < 2; i++) begin
      tick;
      drive(1'b1, ops[i], as[i], 32'h0, 1'b0);
      #2;
      vecs++;
      if (bus.o_stall !== 1'b1) begin
        errs++; $display("FAIL divz%0d_c0: stall=%b want 1", i, bus.o_stall);
      end
      tick; #2;
      vecs++;
      if (bus.o_we !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_hi !== as[i] || bus.o_lo !== 32'hFFFFFFFF) begin
        errs++;
        $display("FAIL divz%0d_c1: we=%b stall=%b hi=%h lo=%h want 1 0 %h ffffffff",
                 i, bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo, as[i]);
      end
      tick;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #2;
      vecs++;
      if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0) begin
        errs++; $display("FAIL divz%0d_c2: we=%b stall=%b want 0 0", i, bus.o_we, bus.o_stall);
      end
      last_hi = as[i];
      last_lo = 32'hFFFFFFFF;
    end
  endtask

  task automatic test_flush;
    int bad;
    // Flush a running divide at cycle 10
    tick;
    drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 10; c++) tick;
    bus.i_flush = 1'b1;
    #2;
    vecs++;
    if (bus.o_stall !== 1'b0 || bus.o_we !== 1'b0) begin
      errs++; $display("FAIL flush_c10: stall=%b we=%b want 0 0", bus.o_stall, bus.o_we);
    end
    bad = 0;
    for (int c = 11; c <= 45; c++) begin
      tick;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      #2;
      vecs++;
      if (bus.o_stall !== 1'b0 || bus.o_we !== 1'b0 || bus.o_hi !== last_hi || bus.o_lo !== last_lo) begin
        errs++;
        if (bad == 0)
          $display("FAIL flush_idle: cycle %0d stall=%b we=%b hi=%h lo=%h want 0 0 %h %h",
                   c, bus.o_stall, bus.o_we, bus.o_hi, bus.o_lo, last_hi, last_lo);
        bad++;
      end
    end
    // Flush in IDLE blocks acceptance
    tick;
    drive(1'b1, 2'b00, 32'd2, 32'd2, 1'b1);
    #2;
    vecs++;
    if (bus.o_stall !== 1'b0) begin
      errs++; $display("FAIL flush_idle_stall: stall=%b want 0", bus.o_stall);
    end
    tick;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_lo !== last_lo) begin
      errs++; $display("FAIL flush_idle_accept: we=%b lo=%h want 0 %h", bus.o_we, bus.o_lo, last_lo);
    end
    // Flush in the MUL write cycle suppresses the write
    tick;
    drive(1'b1, 2'b00, 32'd3, 32'd5, 1'b0);
    tick;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0) begin
      errs++; $display("FAIL flush_mul_we: we=%b stall=%b want 0 0", bus.o_we, bus.o_stall);
    end
    tick;
    bus.i_flush = 1'b0;
    #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0) begin
      errs++; $display("FAIL flush_mul_after: we=%b stall=%b want 0 0", bus.o_we, bus.o_stall);
    end
  endtask

  task automatic test_reset_mid;
    tick;
    drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 10; c++) tick;
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick;
    rst = 1'b0;
    #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid: we=%b stall=%b hi=%h lo=%h want 0 0 0 0",
               bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo);
    end
    tick; #2;
    vecs++;
    if (bus.o_we !== 1'b0 || bus.o_stall !== 1'b0) begin
      errs++; $display("FAIL reset_mid_idle: we=%b stall=%b want 0 0", bus.o_we, bus.o_stall);
    end
    last_hi = 32'h0;
    last_lo = 32'h0;
  endtask

  task automatic test_back_to_back;
    int we_seen = 0;
    tick;
    drive(1'b1, 2'b11, 32'd100, 32'd7, 1'b0);
    #2;
    if (bus.o_we === 1'b1) we_seen++;
    for (int c = 1; c <= 32; c++) begin
      tick; #2;
      if (bus.o_we === 1'b1) we_seen++;
    end
    // FIX cycle with i_start still high must not re-accept
    tick; #2;
    if (bus.o_we === 1'b1) we_seen++;
    vecs++;
    if (bus.o_we !== 1'b1 || bus.o_stall !== 1'b0 || bus.o_hi !== 32'd2 || bus.o_lo !== 32'd14) begin
      errs++;
      $display("FAIL b2b_fix: we=%b stall=%b hi=%h lo=%h want 1 0 2 e",
               bus.o_we, bus.o_stall, bus.o_hi, bus.o_lo);
    end
    tick;
    drive(1'b1, 2'b00, 32'd6, 32'd7, 1'b0);
    #2;
    if (bus.o_we === 1'b1) we_seen++;
    vecs++;
    if (bus.o_stall !== 1'b1 || bus.o_we !== 1'b0) begin
      errs++; $display("FAIL b2b_accept: stall=%b we=%b want 1 0", bus.o_stall, bus.o_we);
    end
    tick;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    #2;
    if (bus.o_we === 1'b1) we_seen++;
    vecs++;
    if (bus.o_we !== 1'b1 || bus.o_hi !== 32'd0 || bus.o_lo !== 32'd42) begin
      errs++;
      $display("FAIL b2b_mult: we=%b hi=%h lo=%h want 1 0 2a", bus.o_we, bus.o_hi, bus.o_lo);
    end
    tick; #2;
    if (bus.o_we === 1'b1) we_seen++;
    tick; #2;
    if (bus.o_we === 1'b1) we_seen++;
    vecs++;
    if (we_seen != 2) begin
      errs++; $display("FAIL b2b_we_count: got %0d write pulses want 2", we_seen);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
